// File: rtl/soc_trace_event_decoder.sv
// Simulation trace event decoder.
// Watches retired instructions for `addi x0,x0,imm` markers, pairs each marker
// with the captured r3 value and queues the resulting exit/report/putc event in
// a small first-word-fall-through FIFO. A sticky terminate flag and exit code
// are held once an exit marker retires.

module soc_trace_event_decoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CORE_ID    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trace_valid_i,
    input  logic [31:0] trace_insn_i,
    input  logic [31:0] r3_i,
    output logic        ev_valid_o,
    input  logic        ev_ready_i,
    output logic [1:0]  ev_type_o,
    output logic [31:0] ev_data_o,
    output logic [15:0] ev_core_o,
    output logic        terminated_o,
    output logic [31:0] exit_code_o,
    output logic        overflow_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] TypeExit   = 2'd0;
    localparam logic [1:0] TypeReport = 2'd1;
    localparam logic [1:0] TypePutc   = 2'd2;

    typedef enum logic [0:0] {StRun, StDone} state_e;

    state_e state_q, state_d;

    // Marker decode
    logic        is_marker;
    logic        is_exit;
    logic [1:0]  marker_type;

    // FIFO state; each entry is {type, data}
    logic [33:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;
    logic [31:0]     exit_code_q;

    logic fifo_empty, fifo_full;
    logic pop, push_req, push_ok, drop;
    logic [33:0] head;

    // Decode a retiring instruction into a marker code (addi x0,x0,imm only)
    always_comb begin
        is_marker   = 1'b0;
        is_exit     = 1'b0;
        marker_type = TypeExit;
        if (trace_insn_i[19:0] == 20'h00013) begin
            unique case (trace_insn_i[31:20])
                12'h001: begin is_marker = 1'b1; is_exit = 1'b1; marker_type = TypeExit;   end
                12'h002: begin is_marker = 1'b1;                 marker_type = TypeReport; end
                12'h004: begin is_marker = 1'b1;                 marker_type = TypePutc;   end
                default: ;
            endcase
        end
    end

    // Terminate FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Terminate FSM: next state, RUN -> DONE on a retiring exit marker
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (trace_valid_i && is_exit) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StRun;
        endcase
    end

    // Terminate FSM: outputs; markers are only accepted while running
    always_comb begin
        terminated_o = (state_q == StDone);
        push_req     = trace_valid_i && is_marker && (state_q == StRun);
    end

    // FIFO handshake; a full FIFO still accepts a push if the head pops this cycle
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CntW'(FIFO_DEPTH));
        pop        = !fifo_empty && ev_ready_i;
        push_ok    = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
    end

    // Storage array carries no reset: the count alone defines which entries are live
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {marker_type, r3_i};
        end
    end

    // Pointers, count, sticky overflow and exit code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            exit_code_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_ok && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push_ok && pop) begin
                count_q <= count_q - CntW'(1);
            end
            if (drop) overflow_q <= 1'b1;
            // Exit state is captured even when the exit event itself is dropped
            if (push_req && is_exit) exit_code_q <= r3_i;
        end
    end

    // Head-of-FIFO outputs, forced to zero while empty
    always_comb begin
        head        = mem_q[rd_ptr_q];
        ev_valid_o  = !fifo_empty;
        ev_type_o   = fifo_empty ? 2'b00 : head[33:32];
        ev_data_o   = fifo_empty ? 32'h0 : head[31:0];
        ev_core_o   = 16'(CORE_ID);
        exit_code_o = exit_code_q;
        overflow_o  = overflow_q;
    end

endmodule

// File: tb/tb_soc_trace_event_decoder.sv
// Self-checking bench for soc_trace_event_decoder: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.

module tb_soc_trace_event_decoder;

    localparam int unsigned Depth = 8;

    localparam logic [31:0] InsnExit   = 32'h0010_0013;
    localparam logic [31:0] InsnReport = 32'h0020_0013;
    localparam logic [31:0] InsnPutc   = 32'h0040_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_valid = 1'b0;
    logic [31:0] trace_insn = '0;
    logic [31:0] r3 = '0;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [1:0]  ev_type;
    logic [31:0] ev_data;
    logic [15:0] ev_core;
    logic        terminated;
    logic [31:0] exit_code;
    logic        overflow;

    soc_trace_event_decoder #(
        .FIFO_DEPTH (Depth),
        .CORE_ID    (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trace_valid_i (trace_valid),
        .trace_insn_i  (trace_insn),
        .r3_i          (r3),
        .ev_valid_o    (ev_valid),
        .ev_ready_i    (ev_ready),
        .ev_type_o     (ev_type),
        .ev_data_o     (ev_data),
        .ev_core_o     (ev_core),
        .terminated_o  (terminated),
        .exit_code_o   (exit_code),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state: queued events as {type, data}
    logic [33:0] m_q[$];
    bit          m_term;
    logic [31:0] m_code;
    bit          m_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Event type of an instruction, or -1 when it is not a recognised marker
    function automatic int marker_code(input logic [31:0] insn);
        if ((insn & 32'h000F_FFFF) != 32'h0000_0013) return -1;
        case (insn >> 20)
            32'd1:   return 0;
            32'd2:   return 1;
            32'd4:   return 2;
            default: return -1;
        endcase
    endfunction

    // Model effect of one clock edge with the currently driven inputs
    task automatic model_edge();
        bit pop;
        int code;
        pop  = (m_q.size() != 0) && ev_ready;
        code = trace_valid ? marker_code(trace_insn) : -1;
        if (pop) void'(m_q.pop_front());
        if (code >= 0 && !m_term) begin
            if (m_q.size() < Depth) m_q.push_back({2'(code), r3});
            else m_ovf = 1'b1;
            if (code == 0) begin
                m_term = 1'b1;
                m_code = r3;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, 32'(ev_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check({tag, ".type"}, 32'(ev_type), 32'(m_q[0][33:32]));
            check({tag, ".data"}, ev_data, m_q[0][31:0]);
        end
        check({tag, ".term"}, 32'(terminated), 32'(m_term));
        check({tag, ".code"}, exit_code, m_code);
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Drive one cycle of inputs (just after a falling edge), then compare at the next one
    task automatic cycle(input string tag, input logic v, input logic [31:0] insn,
                         input logic [31:0] r3v, input logic rdy);
        trace_valid = v;
        trace_insn  = insn;
        r3          = r3v;
        ev_ready    = rdy;
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge
    task automatic apply_reset(input string tag);
        trace_valid = 1'b0;
        ev_ready    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_q.delete();
        m_term = 1'b0;
        m_code = '0;
        m_ovf  = 1'b0;
        check({tag, ".rst_valid"}, 32'(ev_valid), 32'd0);
        check({tag, ".rst_term"}, 32'(terminated), 32'd0);
        check({tag, ".rst_ovf"}, 32'(overflow), 32'd0);
        check({tag, ".rst_code"}, exit_code, 32'd0);
        check({tag, ".rst_type"}, 32'(ev_type), 32'd0);
        check({tag, ".rst_data"}, ev_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_insn();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 2)  return InsnExit;
        if (r < 32) return InsnReport;
        if (r < 52) return InsnPutc;
        if (r < 60) return 32'h0000_0013;
        if (r < 66) return 32'h0030_8013;
        if (r < 72) return 32'h0080_0013;
        if (r < 78) return 32'h0020_0093;
        if (r < 84) return 32'h0020_1013;
        return $urandom;
    endfunction

    initial begin
        m_term = 1'b0;
        m_code = '0;
        m_ovf  = 1'b0;

        // Power-on reset values
        #1;
        check("por.valid", 32'(ev_valid), 32'd0);
        check("por.type", 32'(ev_type), 32'd0);
        check("por.data", ev_data, 32'd0);
        check("por.term", 32'(terminated), 32'd0);
        check("por.code", exit_code, 32'd0);
        check("por.ovf", 32'(overflow), 32'd0);
        check("por.core", 32'(ev_core), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // putc with one-cycle latency, popped on the following edge
        cycle("putc", 1'b1, InsnPutc, 32'h41, 1'b1);
        check("putc.byte", 32'(ev_data[7:0]), 32'h41);
        check("putc.kind", 32'(ev_type), 32'd2);
        cycle("putc_pop", 1'b0, 32'h0, 32'h0, 1'b1);

        // Non-marker encodings produce nothing
        cycle("nop", 1'b1, 32'h0000_0013, 32'h11, 1'b0);
        cycle("rs1", 1'b1, 32'h0030_8013, 32'h22, 1'b0);
        cycle("imm8", 1'b1, 32'h0080_0013, 32'h33, 1'b0);
        cycle("idle_v0", 1'b0, InsnReport, 32'h44, 1'b0);

        // Overflow: nine reports into an eight-entry FIFO, then drain
        for (int i = 1; i <= 9; i++) cycle("fill", 1'b1, InsnReport, 32'(i), 1'b0);
        check("fill.ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 10; i++) cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1);

        // Push and pop together while full: no overflow, new entry lands last
        apply_reset("rst1");
        for (int i = 1; i <= 8; i++) cycle("fill2", 1'b1, InsnReport, 32'(i), 1'b0);
        cycle("fullpp", 1'b1, InsnReport, 32'h55, 1'b1);
        check("fullpp.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) cycle("drain2", 1'b0, 32'h0, 32'h0, 1'b1);

        // Exit marker, then later markers are ignored
        cycle("exit", 1'b1, InsnExit, 32'hDEAD_0001, 1'b1);
        check("exit.code", exit_code, 32'hDEAD_0001);
        check("exit.term", 32'(terminated), 32'd1);
        cycle("post_exit", 1'b1, InsnReport, 32'h7, 1'b1);
        cycle("post_exit2", 1'b1, InsnExit, 32'h9, 1'b1);

        // Reset with events queued, then normal delivery afterwards
        apply_reset("rst2");
        for (int i = 0; i < 3; i++) cycle("q3", 1'b1, InsnPutc, 32'h60 + 32'(i), 1'b0);
        apply_reset("rst3");
        cycle("after_rst", 1'b1, InsnPutc, 32'h5A, 1'b0);
        cycle("after_rst2", 1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized episodes with varying consumer throttling
        for (int ep = 0; ep < 6; ep++) begin
            int unsigned ready_pct;
            ready_pct = $urandom_range(10, 95);
            apply_reset("rnd_rst");
            for (int c = 0; c < 250; c++) begin
                cycle("rnd", ($urandom_range(0, 99) < 75), rand_insn(), $urandom,
                      ($urandom_range(0, 99) < ready_pct));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
